db_lcu_scheduler: RTL and testbench

Frame-level initiator for the deblocking top controller. It walks a picture LCU by LCU in raster order. For each LCU it waits for upstream LCU data, issues a one-cycle start to the controller, then waits for the controller's done pulse. It releases the upstream LCU buffer, advances the coordinates, and signals frame completion. A watchdog aborts the frame if the controller never answers.

---
 rtl/db_pkg.sv | 16 +
 rtl/db_lcu_pos.sv | 60 ++++++
 rtl/db_lcu_scheduler.sv | 112 +++++++++++
 tb/tb_db_lcu_scheduler.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/db_pkg.sv
// Shared types and defaults for the deblocking LCU scheduler.
package db_pkg;

  typedef enum logic [2:0] {
    StIdle    = 3'b000,
    StWaitLcu = 3'b001,
    StStart   = 3'b011,
    StRun     = 3'b010,
    StNext    = 3'b110,
    StDone    = 3'b100
  } db_state_e;

  // A full controller pass takes about 1258 cycles.
  localparam int unsigned DefaultTimeout = 2048;

endpackage

// File: rtl/db_lcu_pos.sv
// Raster-order LCU position counter with latched picture totals and last-LCU flag.
module db_lcu_pos #(
  parameter int unsigned PIC_X_WIDTH = 8,
  parameter int unsigned PIC_Y_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load_i,
  input  logic [PIC_X_WIDTH-1:0] total_x_i,
  input  logic [PIC_Y_WIDTH-1:0] total_y_i,
  input  logic                   adv_i,
  output logic [PIC_X_WIDTH-1:0] x_o,
  output logic [PIC_Y_WIDTH-1:0] y_o,
  output logic                   last_o
);

  logic [PIC_X_WIDTH-1:0] x_q, x_d, tx_q, tx_d;
  logic [PIC_Y_WIDTH-1:0] y_q, y_d, ty_q, ty_d;

  assign last_o = (x_q == tx_q) && (y_q == ty_q);

  always_comb begin
    x_d  = x_q;
    y_d  = y_q;
    tx_d = tx_q;
    ty_d = ty_q;
    if (load_i) begin
      tx_d = total_x_i;
      ty_d = total_y_i;
      x_d  = '0;
      y_d  = '0;
    end else if (adv_i && !last_o) begin
      // Never steps past the latched totals.
      if (x_q == tx_q) begin
        x_d = '0;
        y_d = y_q + PIC_Y_WIDTH'(1);
      end else begin
        x_d = x_q + PIC_X_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_q  <= '0;
      y_q  <= '0;
      tx_q <= '0;
      ty_q <= '0;
    end else begin
      x_q  <= x_d;
      y_q  <= y_d;
      tx_q <= tx_d;
      ty_q <= ty_d;
    end
  end

  assign x_o = x_q;
  assign y_o = y_q;

endmodule

// File: rtl/db_lcu_scheduler.sv
// Frame-level LCU scheduler: waits for upstream data, starts the deblocking controller per LCU
// in raster order, and aborts the frame if the controller does not answer in time.
module db_lcu_scheduler
  import db_pkg::*;
#(
  parameter int unsigned PIC_X_WIDTH = 8,
  parameter int unsigned PIC_Y_WIDTH = 8,
  parameter int unsigned TIMEOUT     = DefaultTimeout
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   sys_start_i,
  input  logic [PIC_X_WIDTH-1:0] sys_total_x_i,
  input  logic [PIC_Y_WIDTH-1:0] sys_total_y_i,
  input  logic                   lcu_ready_i,
  input  logic                   db_done_i,
  output logic                   db_start_o,
  output logic [PIC_X_WIDTH-1:0] db_x_o,
  output logic [PIC_Y_WIDTH-1:0] db_y_o,
  output logic                   lcu_ack_o,
  output logic                   sys_done_o,
  output logic                   busy_o,
  output logic                   err_timeout_o
);

  localparam int unsigned        WdW    = $clog2(TIMEOUT);
  localparam logic [WdW-1:0]     WdLast = WdW'(TIMEOUT - 1);

  db_state_e      state_q, state_d;
  logic [WdW-1:0] wd_q, wd_d;
  logic           err_q, err_d;
  logic           pos_load, pos_adv, pos_last;

  db_lcu_pos #(
    .PIC_X_WIDTH(PIC_X_WIDTH),
    .PIC_Y_WIDTH(PIC_Y_WIDTH)
  ) u_pos (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (pos_load),
    .total_x_i(sys_total_x_i),
    .total_y_i(sys_total_y_i),
    .adv_i    (pos_adv),
    .x_o      (db_x_o),
    .y_o      (db_y_o),
    .last_o   (pos_last)
  );

  always_comb begin
    state_d  = state_q;
    wd_d     = wd_q;
    err_d    = err_q;
    pos_load = 1'b0;
    pos_adv  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (sys_start_i) begin
          state_d  = StWaitLcu;
          pos_load = 1'b1;
          err_d    = 1'b0;
        end
      end
      StWaitLcu: begin
        if (lcu_ready_i) state_d = StStart;
      end
      StStart: begin
        state_d = StRun;
        wd_d    = '0;
      end
      StRun: begin
        // A done on the watchdog's final cycle still counts as success.
        if (db_done_i) begin
          state_d = StNext;
        end else if (wd_q == WdLast) begin
          state_d = StDone;
          err_d   = 1'b1;
        end else begin
          wd_d = wd_q + WdW'(1);
        end
      end
      StNext: begin
        if (pos_last) begin
          state_d = StDone;
        end else begin
          state_d = StWaitLcu;
          pos_adv = 1'b1;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      wd_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
      err_q   <= err_d;
    end
  end

  assign db_start_o    = (state_q == StStart);
  assign lcu_ack_o     = (state_q == StNext);
  assign sys_done_o    = (state_q == StDone);
  assign busy_o        = (state_q != StIdle);
  assign err_timeout_o = err_q;

endmodule

// File: tb/tb_db_lcu_scheduler.sv
// Bench for db_lcu_scheduler: two instances (long and short watchdog) share stimulus and are
// checked every cycle against a cycle-level behavioural model, plus hand-computed checks.
module tb_db_lcu_scheduler;

  localparam int TmoA = 2048;
  localparam int TmoB = 64;

  localparam int PhIdle  = 0;
  localparam int PhWait  = 1;
  localparam int PhStart = 2;
  localparam int PhRun   = 3;
  localparam int PhNext  = 4;
  localparam int PhDone  = 5;

  typedef struct {
    int ph;
    int x;
    int y;
    int tx;
    int ty;
    int run_cycles;
    bit err;
  } mdl_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sys_start = 1'b0;
  logic [7:0] tot_x = 8'd0;
  logic [7:0] tot_y = 8'd0;
  logic       lcu_ready = 1'b0;
  logic       db_done = 1'b0;

  logic       a_start, a_ack, a_sdone, a_busy, a_err;
  logic [7:0] a_x, a_y;
  logic       b_start, b_ack, b_sdone, b_busy, b_err;
  logic [7:0] b_x, b_y;

  always #5 clk = ~clk;

  db_lcu_scheduler #(.PIC_X_WIDTH(8), .PIC_Y_WIDTH(8), .TIMEOUT(TmoA)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .sys_start_i(sys_start), .sys_total_x_i(tot_x),
    .sys_total_y_i(tot_y), .lcu_ready_i(lcu_ready), .db_done_i(db_done),
    .db_start_o(a_start), .db_x_o(a_x), .db_y_o(a_y), .lcu_ack_o(a_ack),
    .sys_done_o(a_sdone), .busy_o(a_busy), .err_timeout_o(a_err)
  );

  db_lcu_scheduler #(.PIC_X_WIDTH(8), .PIC_Y_WIDTH(8), .TIMEOUT(TmoB)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .sys_start_i(sys_start), .sys_total_x_i(tot_x),
    .sys_total_y_i(tot_y), .lcu_ready_i(lcu_ready), .db_done_i(db_done),
    .db_start_o(b_start), .db_x_o(b_x), .db_y_o(b_y), .lcu_ack_o(b_ack),
    .sys_done_o(b_sdone), .busy_o(b_busy), .err_timeout_o(b_err)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Behavioural model: one call advances one clock edge.
  function automatic mdl_t step(mdl_t m, int tmo, bit rstn, bit st, int tx, int ty, bit rdy,
                                bit dn);
    mdl_t n = m;
    if (!rstn) begin
      n = '{default: 0};
      return n;
    end
    case (m.ph)
      PhIdle: if (st) begin
        n.ph = PhWait; n.tx = tx; n.ty = ty; n.x = 0; n.y = 0; n.err = 1'b0;
      end
      PhWait: if (rdy) n.ph = PhStart;
      PhStart: begin n.ph = PhRun; n.run_cycles = 0; end
      PhRun: begin
        if (dn) n.ph = PhNext;
        else if (m.run_cycles + 1 == tmo) begin n.ph = PhDone; n.err = 1'b1; end
        else n.run_cycles = m.run_cycles + 1;
      end
      PhNext: begin
        if (m.x == m.tx && m.y == m.ty) n.ph = PhDone;
        else begin
          n.ph = PhWait;
          if (m.x == m.tx) begin n.x = 0; n.y = m.y + 1; end
          else n.x = m.x + 1;
        end
      end
      default: n.ph = PhIdle;
    endcase
    return n;
  endfunction

  function automatic logic [31:0] exp_vec(mdl_t m);
    logic [7:0] ex = m.x[7:0];
    logic [7:0] ey = m.y[7:0];
    return {11'd0, m.ph == PhStart, ex, ey, m.ph == PhNext, m.ph == PhDone, m.ph != PhIdle, m.err};
  endfunction

  mdl_t ma = '{default: 0};
  mdl_t mb = '{default: 0};
  bit   chk_en = 1'b0;
  int   cyc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    ma  <= step(ma, TmoA, rst_n, sys_start, int'(tot_x), int'(tot_y), lcu_ready, db_done);
    mb  <= step(mb, TmoB, rst_n, sys_start, int'(tot_x), int'(tot_y), lcu_ready, db_done);
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("dut_a outputs vs model",
            {11'd0, a_start, a_x, a_y, a_ack, a_sdone, a_busy, a_err}, exp_vec(ma));
      check("dut_b outputs vs model",
            {11'd0, b_start, b_x, b_y, b_ack, b_sdone, b_busy, b_err}, exp_vec(mb));
    end
  end

  int n_start = 0, n_ack = 0, n_sdone = 0, nb_ack = 0, nb_sdone = 0;
  int ack_cyc = 0, sdone_cyc = 0;
  int xs[$];
  int ys[$];

  always @(negedge clk) begin
    if (a_start) begin
      n_start <= n_start + 1;
      xs.push_back(int'(a_x));
      ys.push_back(int'(a_y));
    end
    if (a_ack) begin n_ack <= n_ack + 1; ack_cyc <= cyc; end
    if (a_sdone) begin n_sdone <= n_sdone + 1; sdone_cyc <= cyc; end
    if (b_ack) nb_ack <= nb_ack + 1;
    if (b_sdone) nb_sdone <= nb_sdone + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start(input int tx, input int ty);
    tot_x = 8'(tx);
    tot_y = 8'(ty);
    sys_start = 1'b1;
    @(negedge clk);
    sys_start = 1'b0;
  endtask

  task automatic wait_start(output bit ok);
    int k = 0;
    while (!a_start && k < 4000) begin @(negedge clk); k++; end
    ok = a_start;
    if (!ok) check("wait for db_start_o (bound expired)", 32'd0, 32'd1);
  endtask

  // Done is sampled lat edges after the start cycle.
  task automatic answer(input int lat);
    tick(lat);
    db_done = 1'b1;
    @(negedge clk);
    db_done = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (a_busy && k < 4000) begin @(negedge clk); k++; end
    if (a_busy) check("wait for busy_o low (bound expired)", 32'd1, 32'd0);
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_frame(input int tx, input int ty, input int lat_max);
    bit ok;
    pulse_start(tx, ty);
    for (int i = 0; i < (tx + 1) * (ty + 1); i++) begin
      lcu_ready = 1'b0;
      tick($urandom_range(0, 4));
      lcu_ready = 1'b1;
      wait_start(ok);
      if (!ok) return;
      answer($urandom_range(1, lat_max));
    end
    wait_idle();
  endtask

  initial begin
    bit ok;
    int s0, a0, d0, b0, ba0, bd0, k0, sc;

    // Reset state.
    @(posedge clk);
    chk_en = 1'b1;
    tick(2);
    check("reset busy_o", 32'(a_busy), 32'd0);
    check("reset err_timeout_o", 32'(a_err), 32'd0);
    check("reset db_x_o", 32'(a_x), 32'd0);
    rst_n = 1'b1;
    tick(1);

    // Single-LCU frame.
    lcu_ready = 1'b1;
    s0 = n_start; a0 = n_ack; d0 = n_sdone;
    k0 = cyc;
    pulse_start(0, 0);
    wait_start(ok);
    check("start latency from sys_start", 32'(cyc - k0), 32'd2);
    answer(20);
    wait_idle();
    tick(1);
    check("single: starts", 32'(n_start - s0), 32'd1);
    check("single: acks", 32'(n_ack - a0), 32'd1);
    check("single: sys_done", 32'(n_sdone - d0), 32'd1);
    check("single: sys_done one cycle after ack", 32'(sdone_cyc - ack_cyc), 32'd1);
    check("single: busy low", 32'(a_busy), 32'd0);

    // 3x2 frame, slow controller, ready gap before LCU 2, ignored mid-frame start.
    s0 = n_start; a0 = n_ack; d0 = n_sdone; sc = xs.size();
    pulse_start(2, 1);
    for (int i = 0; i < 6; i++) begin
      if (i == 1) begin
        lcu_ready = 1'b0;
        tick(50);
        check("gap: x held", 32'(a_x), 32'd1);
        check("gap: y held", 32'(a_y), 32'd0);
        check("gap: no start while not ready", 32'(n_start - s0), 32'd1);
        lcu_ready = 1'b1;
      end
      wait_start(ok);
      if (!ok) break;
      if (i == 2) begin
        tot_x = 8'd7; tot_y = 8'd7; sys_start = 1'b1;
        @(negedge clk);
        sys_start = 1'b0; tot_x = 8'd2; tot_y = 8'd1;
        answer(1257);
      end else begin
        answer(1258);
      end
    end
    wait_idle();
    tick(1);
    check("3x2: starts", 32'(n_start - s0), 32'd6);
    check("3x2: acks", 32'(n_ack - a0), 32'd6);
    check("3x2: sys_done", 32'(n_sdone - d0), 32'd1);
    check("3x2: sys_done after last ack", 32'(sdone_cyc - ack_cyc), 32'd1);
    check("3x2: no error", 32'(a_err), 32'd0);
    if (xs.size() - sc == 6) begin
      for (int yy = 0; yy < 2; yy++)
        for (int xx = 0; xx < 3; xx++) begin
          check("3x2: start x", 32'(xs[sc + yy * 3 + xx]), 32'(xx));
          check("3x2: start y", 32'(ys[sc + yy * 3 + xx]), 32'(yy));
        end
    end

    // Watchdog abort on the short-timeout instance.
    reset_pulse();
    ba0 = nb_ack; bd0 = nb_sdone;
    pulse_start(0, 0);
    wait_start(ok);
    k0 = cyc;
    begin
      int k = 0;
      while (!b_sdone && k < 200) begin @(negedge clk); k++; end
    end
    check("timeout: sys_done cycles after RUN entry", 32'(cyc - k0 - 1), 32'd64);
    check("timeout: err with sys_done", 32'(b_err), 32'd1);
    check("timeout: no ack", 32'(nb_ack - ba0), 32'd0);
    answer(2);
    tick(3);
    check("timeout: stray done keeps err", 32'(b_err), 32'd1);
    check("timeout: stray done keeps idle", 32'(b_busy), 32'd0);
    wait_idle();
    pulse_start(0, 0);
    check("timeout: new start clears err", 32'(b_err), 32'd0);
    wait_start(ok);
    answer(10);
    wait_idle();

    // Done on the watchdog's final cycle wins.
    ba0 = nb_ack; bd0 = nb_sdone;
    pulse_start(0, 0);
    wait_start(ok);
    answer(64);
    tick(3);
    check("edge done: ack", 32'(nb_ack - ba0), 32'd1);
    check("edge done: sys_done", 32'(nb_sdone - bd0), 32'd1);
    check("edge done: no error", 32'(b_err), 32'd0);

    // Reset during RUN of LCU (1,0).
    pulse_start(2, 1);
    wait_start(ok);
    answer(10);
    wait_start(ok);
    check("midreset: at (1,0)", 32'(a_x), 32'd1);
    tick(5);
    d0 = n_sdone;
    reset_pulse();
    check("midreset: outputs cleared",
          {11'd0, a_start, a_x, a_y, a_ack, a_sdone, a_busy, a_err}, 32'd0);
    tick(5);
    check("midreset: no sys_done", 32'(n_sdone - d0), 32'd0);
    pulse_start(0, 0);
    wait_start(ok);
    check("midreset: restart x", 32'(a_x), 32'd0);
    check("midreset: restart y", 32'(a_y), 32'd0);
    answer(5);
    wait_idle();

    // Randomized frames, with stray dones between frames.
    for (int r = 0; r < 8; r++) begin
      int tx = $urandom_range(0, 3);
      int ty = $urandom_range(0, 2);
      s0 = n_start; d0 = n_sdone;
      run_frame(tx, ty, (r % 3 == 0) ? 80 : 40);
      tick(1);
      check("random: starts", 32'(n_start - s0), 32'((tx + 1) * (ty + 1)));
      check("random: sys_done", 32'(n_sdone - d0), 32'd1);
      for (int j = 0; j < 4; j++) begin
        db_done = 1'($urandom_range(0, 1));
        @(negedge clk);
      end
      db_done = 1'b0;
      tick(2);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global time limit: simulation did not complete");
    $fatal(1);
  end

endmodule
